// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the control word carried down the pipeline.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BGT   = 6'b000111;
   localparam logic [5:0] OP_BNEZ  = 6'b000101;
   localparam logic [5:0] OP_BGEZ  = 6'b000001;

   localparam logic [1:0] ALU_SRC2_REG  = 2'b00;
   localparam logic [1:0] ALU_SRC2_IMM  = 2'b01;
   localparam logic [1:0] ALU_SRC2_ZERO = 2'b10;

   localparam logic WB_DATA_ALU = 1'b0;
   localparam logic WB_DATA_DM  = 1'b1;

   typedef struct packed {
      logic [1:0] src2;
      logic       data_sel;
      logic       branch;
      logic       dm_read;
      logic       dm_write;
      logic       reg_write;
      logic [5:0] op;
      logic [5:0] funct;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] waddr;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_BUBBLE = '0;

   // Instructions that read rt as a source operand (not as a destination).
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BGT) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ID-stage decoder: instruction word -> control word (pure combinational).
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter bit EXT_BR_EN = 1'b1
) (
   input  logic [31:0] instr,
   output ctrl_word_t  word
);

   logic [5:0] opcode;
   logic       known;

   assign opcode = instr[31:26];

   // Opcode table; unknown opcodes fall through to an all-zero bubble.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      word  = CTRL_BUBBLE;
      known = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            known          = 1'b1;
            word.src2      = ALU_SRC2_REG;
            word.waddr     = instr[15:11];
            word.reg_write = 1'b1;
         end
         OP_ADDI: begin
            known          = 1'b1;
            word.src2      = ALU_SRC2_IMM;
            word.waddr     = instr[20:16];
            word.reg_write = 1'b1;
         end
         OP_LW: begin
            known          = 1'b1;
            word.src2      = ALU_SRC2_IMM;
            word.dm_read   = 1'b1;
            word.data_sel  = WB_DATA_DM;
            word.waddr     = instr[20:16];
            word.reg_write = 1'b1;
         end
         OP_SW: begin
            known          = 1'b1;
            word.src2      = ALU_SRC2_IMM;
            word.dm_write  = 1'b1;
         end
         OP_BEQ: begin
            known          = 1'b1;
            word.src2      = ALU_SRC2_REG;
            word.branch    = 1'b1;
         end
         OP_BGT: begin
            if (EXT_BR_EN) begin
               known       = 1'b1;
               word.src2   = ALU_SRC2_REG;
               word.branch = 1'b1;
            end
         end
         OP_BNEZ, OP_BGEZ: begin
            if (EXT_BR_EN) begin
               known       = 1'b1;
               word.src2   = ALU_SRC2_ZERO;
               word.branch = 1'b1;
            end
         end
         default: ;
      endcase

      if (known) begin
         word.op    = opcode;
         word.funct = instr[5:0];
         word.rs    = instr[25:21];
         word.rt    = instr[20:16];
      end

      // r0 is hard-wired, so a write to it is dropped here (covers NOP).
      if (word.waddr == 5'd0)
         word.reg_write = 1'b0;
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: decode in ID, carry control through ID/EX, EX/MEM, MEM/WB,
// with load-use stall, branch flush and global hold.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter bit EXT_BR_EN      = 1'b1,
   parameter bit BR_RESOLVE_MEM = 1'b0,
   parameter bit LOAD_USE_EN    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_i,
   input  logic        hold_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [1:0]  ex_alu_src2_o,
   output logic [5:0]  ex_alu_op_o,
   output logic [5:0]  ex_funct_o,
   output logic [4:0]  ex_rs_o,
   output logic [4:0]  ex_rt_o,
   output logic        mem_branch_o,
   output logic        mem_dm_read_o,
   output logic        mem_dm_write_o,
   output logic        wb_reg_write_o,
   output logic        wb_data_sel_o,
   output logic [4:0]  wb_waddr_o
);

   ctrl_word_t id_word;
   ctrl_word_t ex_q;
   ctrl_word_t mem_q;
   ctrl_word_t wb_q;
   logic       load_use;

   ctrl_decode #(.EXT_BR_EN(EXT_BR_EN)) u_decode (
      .instr (instr_i),
      .word  (id_word)
   );

   // Load in EX whose destination is a source of the ID instruction.
   always_comb begin
      load_use = 1'b0;
      if (LOAD_USE_EN && ex_q.dm_read && (ex_q.waddr != 5'd0)) begin
         if (ex_q.waddr == id_word.rs)
            load_use = 1'b1;
         else if (uses_rt(id_word.op) && (ex_q.waddr == id_word.rt))
            load_use = 1'b1;
      end
   end

   // A taken branch squashes the ID instruction anyway, so no stall is needed.
   assign stall_o = load_use & ~flush_i;

   // Stage registers; priority reset > hold > flush > stall > advance.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking updates so every stage samples the pre-edge value of its predecessor.
      if (rst_i) begin
         ex_q  <= CTRL_BUBBLE;
         mem_q <= CTRL_BUBBLE;
         wb_q  <= CTRL_BUBBLE;
      end else if (!hold_i) begin
         wb_q <= mem_q;
         if (flush_i) begin
            ex_q  <= CTRL_BUBBLE;
            mem_q <= BR_RESOLVE_MEM ? CTRL_BUBBLE : ex_q;
         end else if (load_use) begin
            ex_q  <= CTRL_BUBBLE;
            mem_q <= ex_q;
         end else begin
            ex_q  <= id_word;
            mem_q <= ex_q;
         end
      end
   end

   assign ex_alu_src2_o  = ex_q.src2;
   assign ex_alu_op_o    = ex_q.op;
   assign ex_funct_o     = ex_q.funct;
   assign ex_rs_o        = ex_q.rs;
   assign ex_rt_o        = ex_q.rt;
   assign mem_branch_o   = mem_q.branch;
   assign mem_dm_read_o  = mem_q.dm_read;
   assign mem_dm_write_o = mem_q.dm_write;
   assign wb_reg_write_o = wb_q.reg_write;
   assign wb_data_sel_o  = wb_q.data_sel;
   assign wb_waddr_o     = wb_q.waddr;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench: two instances (default params, and EXT_BR_EN=0/BR_RESOLVE_MEM=1) driven
// in lockstep and compared against an instruction-level reference model.
module tb_pipe_ctrl_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] instr_i = 32'd0;
   logic        hold_i = 1'b0;
   logic        flush_i = 1'b0;

   logic        stall_a, stall_b;
   logic [1:0]  ex_alu_src2_a, ex_alu_src2_b;
   logic [5:0]  ex_alu_op_a, ex_alu_op_b, ex_funct_a, ex_funct_b;
   logic [4:0]  ex_rs_a, ex_rs_b, ex_rt_a, ex_rt_b;
   logic        mem_branch_a, mem_branch_b, mem_dm_read_a, mem_dm_read_b;
   logic        mem_dm_write_a, mem_dm_write_b;
   logic        wb_reg_write_a, wb_reg_write_b, wb_data_sel_a, wb_data_sel_b;
   logic [4:0]  wb_waddr_a, wb_waddr_b;

   always #5 clk_i = ~clk_i;

   pipe_ctrl_unit #(.EXT_BR_EN(1'b1), .BR_RESOLVE_MEM(1'b0), .LOAD_USE_EN(1'b1)) dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .hold_i(hold_i), .flush_i(flush_i),
      .stall_o(stall_a), .ex_alu_src2_o(ex_alu_src2_a), .ex_alu_op_o(ex_alu_op_a),
      .ex_funct_o(ex_funct_a), .ex_rs_o(ex_rs_a), .ex_rt_o(ex_rt_a),
      .mem_branch_o(mem_branch_a), .mem_dm_read_o(mem_dm_read_a), .mem_dm_write_o(mem_dm_write_a),
      .wb_reg_write_o(wb_reg_write_a), .wb_data_sel_o(wb_data_sel_a), .wb_waddr_o(wb_waddr_a)
   );

   pipe_ctrl_unit #(.EXT_BR_EN(1'b0), .BR_RESOLVE_MEM(1'b1), .LOAD_USE_EN(1'b1)) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .hold_i(hold_i), .flush_i(flush_i),
      .stall_o(stall_b), .ex_alu_src2_o(ex_alu_src2_b), .ex_alu_op_o(ex_alu_op_b),
      .ex_funct_o(ex_funct_b), .ex_rs_o(ex_rs_b), .ex_rt_o(ex_rt_b),
      .mem_branch_o(mem_branch_b), .mem_dm_read_o(mem_dm_read_b), .mem_dm_write_o(mem_dm_write_b),
      .wb_reg_write_o(wb_reg_write_b), .wb_data_sel_o(wb_data_sel_b), .wb_waddr_o(wb_waddr_b)
   );

   wire [33:0] obs_a = {ex_alu_src2_a, ex_alu_op_a, ex_funct_a, ex_rs_a, ex_rt_a,
                        mem_branch_a, mem_dm_read_a, mem_dm_write_a,
                        wb_reg_write_a, wb_data_sel_a, wb_waddr_a};
   wire [33:0] obs_b = {ex_alu_src2_b, ex_alu_op_b, ex_funct_b, ex_rs_b, ex_rt_b,
                        mem_branch_b, mem_dm_read_b, mem_dm_write_b,
                        wb_reg_write_b, wb_data_sel_b, wb_waddr_b};

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0] src2;
      logic       dsel, br, rd, wr, rw;
      logic [5:0] op, funct;
      logic [4:0] rs, rt, wa;
   } ref_t;

   bit   ext_k [2] = '{1'b1, 1'b0};
   bit   brm_k [2] = '{1'b0, 1'b1};
   ref_t m_ex [2];
   ref_t m_mem [2];
   ref_t m_wb [2];
   bit   model_valid = 1'b0;

   int   n_pass  = 0;
   int   n_total = 0;
   logic last_stall_a, last_stall_b;

   function automatic ref_t empty_slot();
      ref_t r;
      r = '{default: '0};
      return r;
   endfunction

   // What the instruction means, straight from the opcode table.
   function automatic ref_t ref_decode(input logic [31:0] ins, input bit ext);
      ref_t r;
      bit   ok;
      r  = empty_slot();
      ok = 1'b1;
      unique case (ins[31:26])
         6'd0:  begin r.wa = ins[15:11]; r.rw = 1'b1; end
         6'd8:  begin r.src2 = 2'd1; r.wa = ins[20:16]; r.rw = 1'b1; end
         6'd35: begin r.src2 = 2'd1; r.rd = 1'b1; r.dsel = 1'b1; r.wa = ins[20:16]; r.rw = 1'b1; end
         6'd43: begin r.src2 = 2'd1; r.wr = 1'b1; end
         6'd4:  r.br = 1'b1;
         6'd7:  begin ok = ext; r.br = ext; end
         6'd5, 6'd1: begin ok = ext; r.br = ext; r.src2 = ext ? 2'd2 : 2'd0; end
         default: ok = 1'b0;
      endcase
      if (ok) begin
         r.op = ins[31:26]; r.funct = ins[5:0]; r.rs = ins[25:21]; r.rt = ins[20:16];
      end
      if (r.wa == 5'd0) r.rw = 1'b0;
      return r;
   endfunction

   function automatic bit ref_hazard(input int k, input logic [31:0] ins, input bit flush);
      ref_t id;
      bit   rt_src;
      id     = ref_decode(ins, ext_k[k]);
      rt_src = (id.op == 6'd0) || (id.op == 6'd4) || (id.op == 6'd7) || (id.op == 6'd43);
      if (flush || !m_ex[k].rd || m_ex[k].wa == 5'd0) return 1'b0;
      return (m_ex[k].wa == id.rs) || (rt_src && m_ex[k].wa == id.rt);
   endfunction

   function automatic logic [33:0] ref_vec(input int k);
      return {m_ex[k].src2, m_ex[k].op, m_ex[k].funct, m_ex[k].rs, m_ex[k].rt,
              m_mem[k].br, m_mem[k].rd, m_mem[k].wr,
              m_wb[k].rw, m_wb[k].dsel, m_wb[k].wa};
   endfunction

   task automatic check(input logic [63:0] observed, input logic [63:0] expected, input string tag);
      n_total++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // One clock: drive inputs, check combinational stall, advance model, check stage outputs.
   task automatic step(input logic [31:0] ins, input bit hold, input bit flush, input bit rst);
      bit   hz [2];
      ref_t id;
      ref_t old_ex, old_mem;
      instr_i = ins; hold_i = hold; flush_i = flush; rst_i = rst;
      #1;
      hz[0] = ref_hazard(0, ins, flush);
      hz[1] = ref_hazard(1, ins, flush);
      last_stall_a = stall_a;
      last_stall_b = stall_b;
      if (model_valid) begin
         check(stall_a, hz[0], "stall_a");
         check(stall_b, hz[1], "stall_b");
      end
      @(posedge clk_i);
      for (int k = 0; k < 2; k++) begin
         id      = ref_decode(ins, ext_k[k]);
         old_ex  = m_ex[k];
         old_mem = m_mem[k];
         if (rst) begin
            m_ex[k] = empty_slot(); m_mem[k] = empty_slot(); m_wb[k] = empty_slot();
         end else if (!hold) begin
            m_wb[k] = old_mem;
            if (flush) begin
               m_ex[k]  = empty_slot();
               m_mem[k] = brm_k[k] ? empty_slot() : old_ex;
            end else if (hz[k]) begin
               m_ex[k]  = empty_slot();
               m_mem[k] = old_ex;
            end else begin
               m_ex[k]  = id;
               m_mem[k] = old_ex;
            end
         end
      end
      if (rst) model_valid = 1'b1;
      #1;
      if (model_valid) begin
         check(obs_a, ref_vec(0), "stages_a");
         check(obs_b, ref_vec(1), "stages_b");
      end
   endtask

   function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   localparam logic [31:0] NOP = 32'h0000_0024;

   initial begin
      logic [31:0] ins;
      logic [5:0]  ops [9];
      ops = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd7, 6'd5, 6'd1, 6'd0};
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = empty_slot(); m_mem[k] = empty_slot(); m_wb[k] = empty_slot();
      end
      #1;

      // 1. reset with ADDI present, then release
      step(i_type(6'd8, 5'd0, 5'd1, 16'd5), 1'b0, 1'b0, 1'b1);
      step(i_type(6'd8, 5'd0, 5'd1, 16'd5), 1'b0, 1'b0, 1'b1);
      check(obs_a, 34'd0, "reset_outputs_a");
      check(obs_b, 34'd0, "reset_outputs_b");
      check(stall_a, 1'b0, "reset_stall_a");
      step(i_type(6'd8, 5'd0, 5'd1, 16'd5), 1'b0, 1'b0, 1'b0);
      check(ex_alu_src2_a, 2'b01, "release_src2_imm");

      // 2. LW r8 then ADD r9,r8,r1
      step(i_type(6'd35, 5'd0, 5'd8, 16'd0), 1'b0, 1'b0, 1'b0);
      step(r_type(5'd8, 5'd1, 5'd9, 6'h20), 1'b0, 1'b0, 1'b0);
      check(last_stall_a, 1'b1, "lw_add_stall");
      check({ex_alu_src2_a, ex_alu_op_a, ex_funct_a, ex_rs_a, ex_rt_a}, 24'd0, "lw_add_bubble");
      step(r_type(5'd8, 5'd1, 5'd9, 6'h20), 1'b0, 1'b0, 1'b0);
      check(last_stall_a, 1'b0, "lw_add_stall_once");
      step(NOP, 1'b0, 1'b0, 1'b0);
      step(NOP, 1'b0, 1'b0, 1'b0);
      check(wb_waddr_a, 5'd9, "add_wb_waddr");
      check(wb_reg_write_a, 1'b1, "add_wb_write");

      // 3. rt as destination: stall on rs only
      step(i_type(6'd35, 5'd0, 5'd8, 16'd0), 1'b0, 1'b0, 1'b0);
      step(i_type(6'd8, 5'd8, 5'd9, 16'd4), 1'b0, 1'b0, 1'b0);
      check(last_stall_a, 1'b1, "lw_addi_rs_stall");
      step(i_type(6'd8, 5'd8, 5'd9, 16'd4), 1'b0, 1'b0, 1'b0);
      step(i_type(6'd35, 5'd0, 5'd8, 16'd0), 1'b0, 1'b0, 1'b0);
      step(i_type(6'd8, 5'd0, 5'd8, 16'd1), 1'b0, 1'b0, 1'b0);
      check(last_stall_a, 1'b0, "lw_addi_rt_nostall");

      // 4. BEQ in EX, flush with ADD in ID
      step(i_type(6'd4, 5'd1, 5'd2, 16'd3), 1'b0, 1'b0, 1'b0);
      step(r_type(5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 1'b1, 1'b0);
      check({ex_alu_op_a, ex_rs_a, ex_rt_a}, 16'd0, "flush_ex_bubble");
      check(mem_branch_a, 1'b1, "flush_mem_keeps_beq");
      check(mem_branch_b, 1'b0, "flush_mem_bubble_resolve_mem");

      // 5. hold three cycles mid-stream
      step(i_type(6'd8, 5'd0, 5'd1, 16'd1), 1'b0, 1'b0, 1'b0);
      step(i_type(6'd35, 5'd1, 5'd2, 16'd0), 1'b0, 1'b0, 1'b0);
      step(i_type(6'd43, 5'd2, 5'd3, 16'd0), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(r_type(5'd2, 5'd4, 5'd5, 6'h20), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(NOP, 1'b0, 1'b0, 1'b0);

      // 6. BGEZ with and without extended branches
      step(i_type(6'd1, 5'd3, 5'd0, 16'd8), 1'b0, 1'b0, 1'b0);
      check(ex_alu_src2_a, 2'b10, "bgez_src2_zero");
      check({ex_alu_src2_b, ex_alu_op_b}, 8'd0, "bgez_disabled_bubble");
      step(NOP, 1'b0, 1'b0, 1'b0);
      check(mem_branch_a, 1'b1, "bgez_mem_branch");
      check(mem_branch_b, 1'b0, "bgez_disabled_no_branch");

      // Reset mid-hazard, then randomized traffic
      step(i_type(6'd35, 5'd0, 5'd4, 16'd0), 1'b0, 1'b0, 1'b0);
      step(r_type(5'd4, 5'd4, 5'd6, 6'h20), 1'b0, 1'b0, 1'b1);
      check(obs_a, 34'd0, "reset_mid_stall");
      for (int i = 0; i < 400; i++) begin
         ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63))};
         if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom_range(0, 63));
         step(ins, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
